// File: rtl/enc_stream_arbiter_if.sv
// AXI4-Stream beat channel (tdata/tvalid/tready) used for every stream port of enc_stream_arbiter.
interface enc_stream_arbiter_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/enc_stream_arbiter.sv
// Round-robin sharing of one in-order encryption core between two requesters; a tag FIFO
// steers each result back to its issuer. Optional per-requester beat counters: ARB_BEAT_CNT_EN.
module enc_stream_arbiter #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  enc_stream_arbiter_if.slave    s0,
  enc_stream_arbiter_if.slave    s1,
  enc_stream_arbiter_if.master   c,
  enc_stream_arbiter_if.slave    r,
  enc_stream_arbiter_if.master   m0,
  enc_stream_arbiter_if.master   m1,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_orphan
`ifdef ARB_BEAT_CNT_EN
  ,
  output logic [31:0]            cnt0,
  output logic [31:0]            cnt1
`endif
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              grant_reg;
  logic              grant;
  logic              last_reg;
  logic              c_valid;
  logic              c_hs;

  logic [1:0]        src_valid;
  logic [1:0]        src_ready;
  logic [DATA_W-1:0] src_data [2];
  logic [1:0]        dst_valid;
  logic [1:0]        dst_ready;

  logic              tag_mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              full;
  logic              empty;
  logic              head;
  logic              r_ready;
  logic              push;
  logic              pop;
  logic              err_reg;

  assign src_valid   = {s1.tvalid, s0.tvalid};
  assign src_data[0] = s0.tdata;
  assign src_data[1] = s1.tdata;
  assign dst_ready   = {m1.tready, m0.tready};

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign head  = tag_mem[rd_ptr_reg];

  // With no requester valid the idle grant rests on s0; nothing is issued in that case.
  always_comb begin
    state_next = state_reg;
    grant      = grant_reg;
    if (state_reg == ARB) begin
      grant = (src_valid == 2'b11) ? ~last_reg : src_valid[1];
    end
    c_valid = rst && src_valid[grant] && !full;
    c_hs    = c_valid && c.tready;
    case (state_reg)
      ARB:     if (c_valid && !c.tready) state_next = HOLD;
      HOLD:    if (c_hs) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign src_ready[gi] = rst && (grant == 1'(gi)) && c.tready && !full;
      assign dst_valid[gi] = rst && r.tvalid && !empty && (head == 1'(gi));
    end
  endgenerate

  assign c.tdata   = src_data[grant];
  assign c.tvalid  = c_valid;
  assign s0.tready = src_ready[0];
  assign s1.tready = src_ready[1];

  assign r_ready   = rst && !empty && dst_ready[head];
  assign r.tready  = r_ready;
  assign m0.tdata  = r.tdata;
  assign m1.tdata  = r.tdata;
  assign m0.tvalid = dst_valid[0];
  assign m1.tvalid = dst_valid[1];

  assign push = c_hs;
  assign pop  = r.tvalid && r_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ARB;
      grant_reg  <= 1'b0;
      last_reg   <= 1'b1;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant;
      if (push) begin
        last_reg   <= grant;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // A result with nothing outstanding means core and arbiter have lost sync.
      if (r.tvalid && empty) err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_reg] <= grant;
  end

  assign outstanding = count_reg;
  assign err_orphan  = err_reg;

`ifdef ARB_BEAT_CNT_EN
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] cnt_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (push && (grant == 1'(gi))) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
    end
  endgenerate

  assign cnt0 = g_cnt[0].cnt_reg;
  assign cnt1 = g_cnt[1].cnt_reg;
`endif
endmodule
